// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: widths, FSM states, requester ids and
// the latched request held on the memory port.
package mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

  // Sized by the package widths; the arbiter's ADDR_W/DATA_W must not exceed them.
  typedef struct packed {
    logic                    we;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W-1:0]   wdata;
    logic [MEM_DATA_W/8-1:0] be;
    req_id_e                 owner;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and LSU. Fixed priority (LSU first) by default;
// with MEM_ARB_RR_EN defined, contention goes to whoever was not granted last.
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic    if_req,
  input  logic    ls_req,
`ifdef MEM_ARB_RR_EN
  input  req_id_e last_gnt,
`endif
  output req_id_e gnt_id
);

  // Pick the winner; only meaningful when at least one request is present.
  always_comb begin
    gnt_id = REQ_IF;
`ifdef MEM_ARB_RR_EN
    if (ls_req && if_req) gnt_id = (last_gnt == REQ_LS) ? REQ_IF : REQ_LS;
    else if (ls_req)      gnt_id = REQ_LS;
    else if (if_req)      gnt_id = REQ_IF;
`else
    if (ls_req)           gnt_id = REQ_LS;
    else if (if_req)      gnt_id = REQ_IF;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, LSU) arbiter onto a single memory port with at most one
// transaction in flight. Optional round-robin arbitration: MEM_ARB_RR_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_ack,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_ls_req,
  input  logic                i_ls_we,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_be,
  output logic                o_ls_ack,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic                i_mem_ack,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  arb_state_e        state_q, state_d;
  mem_req_t          lat_q, lat_d;
  req_id_e           gnt_id;
  logic              grant, finish, droppable, drop_q, drop_now;
  logic              if_ack_q, ls_ack_q, if_rv_q, ls_rv_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

`ifdef MEM_ARB_RR_EN
  req_id_e last_q;

  // Remember the most recent grant so contention alternates.
  always_ff @(posedge i_clk) begin
    if (i_rst)      last_q <= REQ_IF;
    else if (grant) last_q <= gnt_id;
  end
`endif

  mem_arb_pick u_pick (
    .if_req   (i_if_req),
    .ls_req   (i_ls_req),
`ifdef MEM_ARB_RR_EN
    .last_gnt (last_q),
`endif
    .gnt_id   (gnt_id)
  );

  // Writes must always report completion; reads (and fetches) may be dropped.
  assign droppable = !(lat_q.owner == REQ_LS && lat_q.we);
  // A flush arriving on the completion edge itself also suppresses the response.
  assign drop_now  = drop_q || (i_flush && droppable);

  // FSM register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, grant/finish strobes and the request to latch on grant.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    finish  = 1'b0;
    lat_d   = '0;
    if (gnt_id == REQ_LS) begin
      lat_d.we    = i_ls_we;
      lat_d.addr  = MEM_ADDR_W'(i_ls_addr);
      lat_d.wdata = MEM_DATA_W'(i_ls_wdata);
      lat_d.be    = (MEM_DATA_W/8)'(i_ls_be);
      lat_d.owner = REQ_LS;
    end else begin
      lat_d.addr  = MEM_ADDR_W'(i_if_addr);
      lat_d.owner = REQ_IF;
    end
    case (state_q)
      ST_IDLE: if ((i_if_req || i_ls_req) && !i_flush) begin
        grant   = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ: if (i_mem_ack) begin
        if (i_mem_rvalid) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (i_mem_rvalid) begin
        finish  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latched request, drop flag, ack/rvalid pulses and response data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lat_q      <= '0;
      drop_q     <= 1'b0;
      if_ack_q   <= 1'b0;
      ls_ack_q   <= 1'b0;
      if_rv_q    <= 1'b0;
      ls_rv_q    <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if_ack_q <= grant && (gnt_id == REQ_IF);
      ls_ack_q <= grant && (gnt_id == REQ_LS);
      if_rv_q  <= finish && !drop_now && (lat_q.owner == REQ_IF);
      ls_rv_q  <= finish && !drop_now && (lat_q.owner == REQ_LS);
      if (grant) lat_q <= lat_d;
      if (finish && !drop_now) begin
        if (lat_q.owner == REQ_IF) if_rdata_q <= i_mem_rdata;
        else                       ls_rdata_q <= i_mem_rdata;
      end
      if (state_d == ST_IDLE)                           drop_q <= 1'b0;
      else if (state_q != ST_IDLE && i_flush && droppable) drop_q <= 1'b1;
    end
  end

  assign o_if_ack    = if_ack_q;
  assign o_ls_ack    = ls_ack_q;
  assign o_if_rvalid = if_rv_q;
  assign o_ls_rvalid = ls_rv_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_mem_req   = (state_q == ST_REQ);
  assign o_mem_we    = lat_q.we;
  assign o_mem_addr  = lat_q.addr[ADDR_W-1:0];
  assign o_mem_wdata = lat_q.wdata[DATA_W-1:0];
  assign o_mem_be    = lat_q.be[DATA_W/8-1:0];

endmodule
